// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle between a controller (master) and a register-file responder (slave).
interface spi_slave_regs_if;
  logic n_cs;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output n_cs, output sclk, output mosi, input miso, input miso_oe);
  modport slave  (input n_cs, input sclk, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_slave_regs.sv
// SPI responder with an N_REGS x 8-bit register file. Frame: {rw, addr[6:0]}, data byte.
// All pins are oversampled in clk; nothing is clocked by sclk.
//  state | meaning
//  IDLE  | waiting for an n_cs fall (armed only once n_cs has been seen high)
//  CMD   | shifting in the command byte
//  DATA  | data byte in on MOSI, read data out on MISO
//  DONE  | 16 bits taken, extra sclk edges ignored until n_cs rises
module spi_slave_regs #(
  parameter bit CPOL   = 1'b0,
  parameter int N_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  spi_slave_regs_if.slave     spi,
  output logic [8*N_REGS-1:0] regs_q,
  output logic                wr_strobe,
  output logic [6:0]          wr_addr,
  output logic [7:0]          wr_data,
  output logic                rd_strobe,
  output logic                frame_err,
  output logic                addr_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

  state_e             state_q, state_d;
  logic               n_cs_s1_q, n_cs_s1_d, n_cs_s2_q, n_cs_s2_d;
  logic               sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_s3_q, sclk_s3_d;
  logic               mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
  logic [1:0]         sync_cnt_q, sync_cnt_d;
  logic               armed_q, armed_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         rx_sr_q, rx_sr_d;
  logic [7:0]         tx_sr_q, tx_sr_d;
  logic               rw_q, rw_d;
  logic [6:0]         addr_q, addr_d;
  logic               loaded_q, loaded_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [6:0]         wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               rd_strobe_q, rd_strobe_d;
  logic               frame_err_q, frame_err_d;
  logic               addr_err_q, addr_err_d;
  logic [8*N_REGS-1:0] regs_d;

  logic               lead_edge, trail_edge;
  logic [7:0]         rx_next;
  logic [7:0]         rd_data;

  function automatic logic is_mapped(input logic [6:0] a);
    return ({25'd0, a} < 32'(N_REGS));
  endfunction

  // Normalise polarity so the leading edge is always a 0->1 transition.
  assign lead_edge  = (sclk_s2_q ^ CPOL) & ~(sclk_s3_q ^ CPOL);
  assign trail_edge = ~(sclk_s2_q ^ CPOL) & (sclk_s3_q ^ CPOL);
  assign rx_next    = {rx_sr_q[6:0], mosi_s2_q};

  assign spi.miso_oe = ~n_cs_s2_q;
  assign spi.miso    = tx_sr_q[7] & ~n_cs_s2_q;

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_strobe = rd_strobe_q;
  assign frame_err = frame_err_q;
  assign addr_err  = addr_err_q;

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < N_REGS; i++) begin
      if (addr_q == 7'(i)) rd_data = regs_q[8*i +: 8];
    end
  end

  always_comb begin
    n_cs_s1_d   = spi.n_cs;
    n_cs_s2_d   = n_cs_s1_q;
    sclk_s1_d   = spi.sclk;
    sclk_s2_d   = sclk_s1_q;
    sclk_s3_d   = sclk_s2_q;
    mosi_s1_d   = spi.mosi;
    mosi_s2_d   = mosi_s1_q;
    sync_cnt_d  = (sync_cnt_q == 2'd2) ? sync_cnt_q : sync_cnt_q + 2'd1;
    armed_d     = armed_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    loaded_d    = loaded_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    addr_err_d  = 1'b0;
    regs_d      = regs_q;

    // Commit one clk after the strobe so regs_q lags wr_strobe by a cycle.
    for (int i = 0; i < N_REGS; i++) begin
      if (wr_strobe_q && wr_addr_q == 7'(i)) regs_d[8*i +: 8] = wr_data_q;
    end

    unique case (state_q)
      IDLE: begin
        if (!armed_q) begin
          // Synchronizer contents are only trustworthy two clk after reset.
          if (sync_cnt_q == 2'd2 && n_cs_s2_q) armed_d = 1'b1;
        end else if (!n_cs_s2_q) begin
          state_d   = CMD;
          bit_cnt_d = 5'd0;
          tx_sr_d   = 8'h00;
          loaded_d  = 1'b0;
        end
      end
      CMD: begin
        if (n_cs_s2_q) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (lead_edge) begin
          rx_sr_d   = rx_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            rw_d       = rx_next[7];
            addr_d     = rx_next[6:0];
            addr_err_d = ~is_mapped(rx_next[6:0]);
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (n_cs_s2_q) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          if (trail_edge) begin
            if (!loaded_q) begin
              loaded_d    = 1'b1;
              tx_sr_d     = (rw_q && is_mapped(addr_q)) ? rd_data : 8'h00;
              rd_strobe_d = rw_q;
            end else begin
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
          end
          if (lead_edge) begin
            rx_sr_d   = rx_next;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              state_d = DONE;
              tx_sr_d = 8'h00;
              if (!rw_q && is_mapped(addr_q)) begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = rx_next;
              end
            end
          end
        end
      end
      DONE: begin
        if (n_cs_s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_cs_s1_q   <= 1'b1;
      n_cs_s2_q   <= 1'b1;
      sclk_s1_q   <= CPOL;
      sclk_s2_q   <= CPOL;
      sclk_s3_q   <= CPOL;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      sync_cnt_q  <= 2'd0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 5'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      loaded_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 8'h00;
      rd_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      regs_q      <= '0;
    end else begin
      n_cs_s1_q   <= n_cs_s1_d;
      n_cs_s2_q   <= n_cs_s2_d;
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_s3_q   <= sclk_s3_d;
      mosi_s1_q   <= mosi_s1_d;
      mosi_s2_q   <= mosi_s2_d;
      sync_cnt_q  <= sync_cnt_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      loaded_q    <= loaded_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
      regs_q      <= regs_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Drives identical SPI frames into a CPOL=0 and a CPOL=1 instance and checks both against a
// byte-array register model.
module tb_spi_slave_regs;
  localparam int N_REGS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic n_cs = 1'b1;
  logic sclk_lvl = 1'b0;
  logic mosi = 1'b0;

  always #5 clk = ~clk;

  spi_slave_regs_if if0 ();
  spi_slave_regs_if if1 ();

  // sclk_lvl rising is the leading edge for both instances.
  assign if0.n_cs = n_cs;
  assign if0.sclk = sclk_lvl;
  assign if0.mosi = mosi;
  assign if1.n_cs = n_cs;
  assign if1.sclk = ~sclk_lvl;
  assign if1.mosi = mosi;

  logic [8*N_REGS-1:0] regs_o [2];
  logic                wr_s [2], rd_s [2], fe [2], ae [2], miso_o [2], oe_o [2];
  logic [6:0]          wa [2];
  logic [7:0]          wd [2];

  assign miso_o[0] = if0.miso;
  assign miso_o[1] = if1.miso;
  assign oe_o[0]   = if0.miso_oe;
  assign oe_o[1]   = if1.miso_oe;

  spi_slave_regs #(.CPOL(1'b0), .N_REGS(N_REGS)) dut0 (
    .clk(clk), .rst(rst), .spi(if0.slave), .regs_q(regs_o[0]),
    .wr_strobe(wr_s[0]), .wr_addr(wa[0]), .wr_data(wd[0]), .rd_strobe(rd_s[0]),
    .frame_err(fe[0]), .addr_err(ae[0])
  );

  spi_slave_regs #(.CPOL(1'b1), .N_REGS(N_REGS)) dut1 (
    .clk(clk), .rst(rst), .spi(if1.slave), .regs_q(regs_o[1]),
    .wr_strobe(wr_s[1]), .wr_addr(wa[1]), .wr_data(wd[1]), .rd_strobe(rd_s[1]),
    .frame_err(fe[1]), .addr_err(ae[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         cnt_wr [2] = '{0, 0};
  int         cnt_rd [2] = '{0, 0};
  int         cnt_fe [2] = '{0, 0};
  int         cnt_ae [2] = '{0, 0};
  logic [6:0] last_wa [2] = '{7'd0, 7'd0};
  logic [7:0] last_wd [2] = '{8'd0, 8'd0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_s[d] === 1'b1) begin
        cnt_wr[d]++;
        last_wa[d] = wa[d];
        last_wd[d] = wd[d];
      end
      if (rd_s[d] === 1'b1) cnt_rd[d]++;
      if (fe[d] === 1'b1)   cnt_fe[d]++;
      if (ae[d] === 1'b1)   cnt_ae[d]++;
    end
  end

  int b_wr [2], b_rd [2], b_fe [2], b_ae [2];
  logic [23:0] cap [2];
  logic [7:0]  ref_regs [N_REGS];

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      b_wr[d] = cnt_wr[d];
      b_rd[d] = cnt_rd[d];
      b_fe[d] = cnt_fe[d];
      b_ae[d] = cnt_ae[d];
    end
  endtask

  function automatic logic [8*N_REGS-1:0] flat_ref();
    logic [8*N_REGS-1:0] r;
    for (int i = 0; i < N_REGS; i++) r[8*i +: 8] = ref_regs[i];
    return r;
  endfunction

  // frame bit i goes out as frame[23-i]; sent = number of sclk periods before n_cs rises.
  task automatic run_frame(input logic [23:0] frame, input int sent, input int rst_bit,
                           output logic [23:0] c0, output logic [23:0] c1);
    c0 = '0;
    c1 = '0;
    @(negedge clk);
    n_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < sent; i++) begin
      if (i == rst_bit) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      mosi = frame[23-i];
      repeat (4) @(negedge clk);
      c0[23-i] = miso_o[0];
      c1[23-i] = miso_o[1];
      sclk_lvl = 1'b1;
      repeat (4) @(negedge clk);
      sclk_lvl = 1'b0;
    end
    repeat (4) @(negedge clk);
    n_cs = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Frame-level rules: what a master should see and what the register file becomes.
  task automatic model_frame(input logic [23:0] frame, input int sent, output logic [23:0] em,
                             output int e_wr, output int e_rd, output int e_ae, output int e_fe);
    logic       rw;
    logic [6:0] a;
    logic       mapped;
    rw     = frame[23];
    a      = frame[22:16];
    mapped = (int'(a) < N_REGS);
    em     = '0;
    if (sent >= 8 && rw && mapped) em[15:8] = ref_regs[a];
    for (int i = sent; i < 24; i++) em[23-i] = 1'b0;
    e_ae = (sent >= 8 && !mapped) ? 1 : 0;
    e_rd = (sent >= 8 && rw) ? 1 : 0;
    e_fe = (sent < 16) ? 1 : 0;
    e_wr = (sent >= 16 && !rw && mapped) ? 1 : 0;
    if (e_wr == 1) ref_regs[a] = frame[15:8];
  endtask

  logic [23:0] em;
  int e_wr, e_rd, e_ae, e_fe;

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (regs_o[d] !== '0) begin
        n_fail++; $display("FAIL reset_regs dut%0d got %h exp 0", d, regs_o[d]);
      end
      n_checks++;
      if ({wr_s[d], rd_s[d], fe[d], ae[d], miso_o[d], oe_o[d], wa[d], wd[d]} !== 21'd0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d got %h exp 0", d,
                           {wr_s[d], rd_s[d], fe[d], ae[d], miso_o[d], oe_o[d], wa[d], wd[d]});
      end
    end
    snap();
    @(negedge clk);
    n_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({oe_o[d], miso_o[d]} !== 2'b10) begin
        n_fail++; $display("FAIL cs_low_oe dut%0d got oe=%b miso=%b exp oe=1 miso=0", d, oe_o[d], miso_o[d]);
      end
    end
    n_cs = 1'b1;
    repeat (8) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cnt_fe[d] - b_fe[d] !== 1 || oe_o[d] !== 1'b0) begin
        n_fail++; $display("FAIL empty_frame_err dut%0d got fe=%0d oe=%b exp fe=1 oe=0", d, cnt_fe[d] - b_fe[d], oe_o[d]);
      end
    end
  endtask

  task automatic test_write();
    snap();
    run_frame(24'h05A500, 16, -1, cap[0], cap[1]);
    model_frame(24'h05A500, 16, em, e_wr, e_rd, e_ae, e_fe);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cnt_wr[d] - b_wr[d] !== 1 || last_wa[d] !== 7'd5 || last_wd[d] !== 8'hA5) begin
        n_fail++; $display("FAIL write_strobe dut%0d got n=%0d a=%h d=%h exp n=1 a=05 d=a5", d,
                           cnt_wr[d] - b_wr[d], last_wa[d], last_wd[d]);
      end
      n_checks++;
      if (regs_o[d][47:40] !== 8'hA5 || regs_o[d] !== flat_ref()) begin
        n_fail++; $display("FAIL write_regs dut%0d got %h exp %h", d, regs_o[d], flat_ref());
      end
    end
  endtask

  task automatic test_read();
    snap();
    run_frame(24'h850000, 16, -1, cap[0], cap[1]);
    model_frame(24'h850000, 16, em, e_wr, e_rd, e_ae, e_fe);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cap[d] !== 24'h00A500) begin
        n_fail++; $display("FAIL read_miso dut%0d got %h exp 00a500", d, cap[d]);
      end
      n_checks++;
      if (cnt_rd[d] - b_rd[d] !== 1 || cnt_wr[d] - b_wr[d] !== 0) begin
        n_fail++; $display("FAIL read_strobes dut%0d got rd=%0d wr=%0d exp rd=1 wr=0", d,
                           cnt_rd[d] - b_rd[d], cnt_wr[d] - b_wr[d]);
      end
    end
  endtask

  task automatic test_unmapped();
    snap();
    run_frame(24'h7F3300, 16, -1, cap[0], cap[1]);
    model_frame(24'h7F3300, 16, em, e_wr, e_rd, e_ae, e_fe);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cnt_ae[d] - b_ae[d] !== 1 || cnt_wr[d] - b_wr[d] !== 0 || regs_o[d] !== flat_ref()) begin
        n_fail++; $display("FAIL unmapped_write dut%0d got ae=%0d wr=%0d regs=%h exp ae=1 wr=0 regs=%h", d,
                           cnt_ae[d] - b_ae[d], cnt_wr[d] - b_wr[d], regs_o[d], flat_ref());
      end
    end
    snap();
    run_frame(24'hFF0000, 16, -1, cap[0], cap[1]);
    model_frame(24'hFF0000, 16, em, e_wr, e_rd, e_ae, e_fe);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cap[d] !== 24'h0 || cnt_ae[d] - b_ae[d] !== 1 || cnt_rd[d] - b_rd[d] !== 1) begin
        n_fail++; $display("FAIL unmapped_read dut%0d got miso=%h ae=%0d rd=%0d exp miso=0 ae=1 rd=1", d,
                           cap[d], cnt_ae[d] - b_ae[d], cnt_rd[d] - b_rd[d]);
      end
    end
  endtask

  task automatic test_abort();
    snap();
    run_frame(24'h037700, 11, -1, cap[0], cap[1]);
    model_frame(24'h037700, 11, em, e_wr, e_rd, e_ae, e_fe);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cnt_fe[d] - b_fe[d] !== 1 || cnt_wr[d] - b_wr[d] !== 0 || regs_o[d][31:24] !== 8'h00) begin
        n_fail++; $display("FAIL abort dut%0d got fe=%0d wr=%0d reg3=%h exp fe=1 wr=0 reg3=00", d,
                           cnt_fe[d] - b_fe[d], cnt_wr[d] - b_wr[d], regs_o[d][31:24]);
      end
    end
    snap();
    run_frame(24'h037700, 16, -1, cap[0], cap[1]);
    model_frame(24'h037700, 16, em, e_wr, e_rd, e_ae, e_fe);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cnt_wr[d] - b_wr[d] !== 1 || cnt_fe[d] - b_fe[d] !== 0 || regs_o[d][31:24] !== 8'h77) begin
        n_fail++; $display("FAIL after_abort dut%0d got wr=%0d fe=%0d reg3=%h exp wr=1 fe=0 reg3=77", d,
                           cnt_wr[d] - b_wr[d], cnt_fe[d] - b_fe[d], regs_o[d][31:24]);
      end
    end
  endtask

  task automatic test_long_frame();
    snap();
    run_frame(24'h023CFF, 24, -1, cap[0], cap[1]);
    model_frame(24'h023CFF, 24, em, e_wr, e_rd, e_ae, e_fe);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cnt_wr[d] - b_wr[d] !== 1 || regs_o[d][23:16] !== 8'h3C || regs_o[d] !== flat_ref()) begin
        n_fail++; $display("FAIL long_write dut%0d got wr=%0d reg2=%h exp wr=1 reg2=3c", d,
                           cnt_wr[d] - b_wr[d], regs_o[d][23:16]);
      end
    end
    snap();
    run_frame(24'h82FFFF, 24, -1, cap[0], cap[1]);
    model_frame(24'h82FFFF, 24, em, e_wr, e_rd, e_ae, e_fe);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cap[d] !== 24'h003C00 || cnt_fe[d] - b_fe[d] !== 0) begin
        n_fail++; $display("FAIL long_read dut%0d got miso=%h fe=%0d exp miso=003c00 fe=0", d,
                           cap[d], cnt_fe[d] - b_fe[d]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    snap();
    run_frame(24'h055500, 16, 12, cap[0], cap[1]);
    for (int i = 0; i < N_REGS; i++) ref_regs[i] = 8'h00;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (regs_o[d] !== '0 || cnt_wr[d] - b_wr[d] !== 0 || cnt_fe[d] - b_fe[d] !== 0) begin
        n_fail++; $display("FAIL rst_mid dut%0d got regs=%h wr=%0d fe=%0d exp regs=0 wr=0 fe=0", d,
                           regs_o[d], cnt_wr[d] - b_wr[d], cnt_fe[d] - b_fe[d]);
      end
    end
    snap();
    run_frame(24'h096600, 16, -1, cap[0], cap[1]);
    model_frame(24'h096600, 16, em, e_wr, e_rd, e_ae, e_fe);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (cnt_wr[d] - b_wr[d] !== 1 || regs_o[d] !== flat_ref()) begin
        n_fail++; $display("FAIL rst_recover dut%0d got wr=%0d regs=%h exp wr=1 regs=%h", d,
                           cnt_wr[d] - b_wr[d], regs_o[d], flat_ref());
      end
    end
  endtask

  task automatic test_random(input int n_frames);
    logic [23:0] frame;
    int          sent, pick;
    for (int f = 0; f < n_frames; f++) begin
      frame = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 19)), 16'($urandom)};
      pick  = $urandom_range(0, 9);
      sent  = (pick < 6) ? 16 : (pick < 8) ? 24 : $urandom_range(1, 15);
      snap();
      run_frame(frame, sent, -1, cap[0], cap[1]);
      model_frame(frame, sent, em, e_wr, e_rd, e_ae, e_fe);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (cap[d] !== em) begin
          n_fail++; $display("FAIL rand_miso f%0d dut%0d frame=%h sent=%0d got %h exp %h", f, d, frame, sent, cap[d], em);
        end
        n_checks++;
        if (cnt_wr[d] - b_wr[d] !== e_wr || cnt_rd[d] - b_rd[d] !== e_rd ||
            cnt_ae[d] - b_ae[d] !== e_ae || cnt_fe[d] - b_fe[d] !== e_fe) begin
          n_fail++; $display("FAIL rand_pulses f%0d dut%0d frame=%h sent=%0d got wr%0d rd%0d ae%0d fe%0d exp wr%0d rd%0d ae%0d fe%0d",
                             f, d, frame, sent, cnt_wr[d] - b_wr[d], cnt_rd[d] - b_rd[d],
                             cnt_ae[d] - b_ae[d], cnt_fe[d] - b_fe[d], e_wr, e_rd, e_ae, e_fe);
        end
        n_checks++;
        if (regs_o[d] !== flat_ref()) begin
          n_fail++; $display("FAIL rand_regs f%0d dut%0d got %h exp %h", f, d, regs_o[d], flat_ref());
        end
        if (e_wr == 1) begin
          n_checks++;
          if (last_wa[d] !== frame[22:16] || last_wd[d] !== frame[15:8]) begin
            n_fail++; $display("FAIL rand_wr_bus f%0d dut%0d got a=%h d=%h exp a=%h d=%h", f, d,
                               last_wa[d], last_wd[d], frame[22:16], frame[15:8]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N_REGS; i++) ref_regs[i] = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_unmapped();
    test_abort();
    test_long_frame();
    test_reset_mid_frame();
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
